uio_bus_arbiter: RTL and testbench
==================================

# uio_bus_arbiter

Round-robin arbiter that shares the 8-bit bidirectional `uio` pin bank of the top-level tile among several internal requesters. Grants one owner at a time, drives `uio_out`/`uio_oe` on the owner's behalf, captures `uio_in` for input owners, and inserts bus turnaround cycles whenever the pin direction changes. Sits directly between the user logic and the `uio_*` ports of `tt_um_topmodule`.

## Interface
- `NREQ`, default 4: number of requesters (2..8).
- `MAX_BURST`, default 8: maximum grant length in cycles (≥1).
- `TURNAROUND`, default 1: idle cycles with `uio_oe=0` inserted on a direction change (≥1).

- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `ena` in 1: tile enable; low blocks new grants only.
- `req` in NREQ: request, one bit per requester.
- `dir` in NREQ: requested direction per requester, 1 = drive pins, 0 = read pins.
- `last` in NREQ: owner marks its final beat.
- `wdata` in 8*NREQ: write data, requester i on bits [8i+7:8i].
- `gnt` out NREQ: one-hot grant, registered.
- `rdata` out 8: registered sample of `uio_in`.
- `rdata_valid` out 1: `rdata` holds a beat captured for an input owner.
- `uio_in` in 8: pin input path.
- `uio_out` out 8: pin output path.
- `uio_oe` out 8: pin output enable, all bits equal.

## Operation
- States: IDLE, TURN, OWN. Registers: `state`, `owner` (index), `own_dir`, `bus_dir`, `ptr` (round-robin start), `beat` counter (width clog2(MAX_BURST+1)), `turn_cnt`.
- IDLE: `gnt=0`, `uio_oe=0`. If `ena=1` and any `req`, select first requester with `req=1` searching upward from `ptr` with wrap. Latch `owner`, `own_dir=dir[owner]`. If `own_dir==bus_dir` → OWN, else → TURN.
- TURN: `gnt=0`, `uio_oe=0`, counts TURNAROUND cycles, then sets `bus_dir=own_dir` and → OWN.
- OWN: `gnt[owner]=1`. `own_dir=1`: `uio_oe=8'hFF`, `uio_out=wdata[owner]` (combinational mux on registered `owner`). `own_dir=0`: `uio_oe=0`, `uio_out=0`, `uio_in` registered into `rdata` each OWN cycle with `rdata_valid=1` the following cycle.
- Grant ends after the current OWN cycle if `last[owner]=1`, or `req[owner]=0`, or `beat` reaches MAX_BURST. On end: `ptr=owner+1` (mod NREQ), `bus_dir` unchanged, → IDLE.
- `dir` and `wdata` of non-owners ignored; `dir[owner]` changes during OWN ignored (`own_dir` latched).
- `ena` falling during TURN/OWN: grant runs to normal completion; no new grant until `ena=1`.
- `rdata` holds its value outside input-owned cycles; `rdata_valid=0` otherwise.
- `uio_out=0` whenever `uio_oe=0`.

## Timing
- Reset (async, any state): `state=IDLE`, `gnt=0`, `uio_oe=0`, `uio_out=0`, `rdata=0`, `rdata_valid=0`, `ptr=0`, `bus_dir=0`, counters 0. Reset mid-grant drops `gnt` and `uio_oe` immediately.
- Request sampled at edge N in IDLE: `gnt` high from cycle N+1 (same direction) or N+1+TURNAROUND (direction change).
- Grant length: 1..MAX_BURST cycles; `last` seen in cycle K → `gnt` low in K+1.
- Minimum gap between consecutive grants: one IDLE cycle, plus TURNAROUND on direction change.
- `uio_oe` and `uio_out` valid in exactly the cycles `gnt` is high for an output owner.
- `rdata`/`rdata_valid`: one cycle after the corresponding input-owned cycle.
- Simultaneous requests: strictly round-robin; no requester waits more than NREQ-1 grants.

## Test plan
- Reset: assert `rst` mid-grant with requester 0 driving `8'hA5` → `gnt=0`, `uio_oe=0`, `uio_out=0` without waiting for a clock edge.
- Single output owner: `req[1]=1`, `dir[1]=1`, `wdata[1]=8'h3C`, `last` on beat 3 → one TURN cycle (bus_dir was 0), `gnt=4'b0010` for 3 cycles, `uio_oe=8'hFF`, `uio_out=8'h3C`, then IDLE.
- Input owner: `req[2]=1`, `dir[2]=0`, `uio_in` stepping 8'h10,8'h11,8'h12 → no TURN, `rdata` 8'h10,8'h11,8'h12 one cycle later with `rdata_valid=1`, `uio_oe=0` throughout.
- Round-robin: all four `req` held, all `dir=0`, no `last` → grants 0,1,2,3,0 each lasting MAX_BURST=8 cycles, one IDLE cycle between.
- Direction switch: requester 0 out then requester 1 in → `uio_oe=0` for one IDLE plus TURNAROUND cycles before `gnt[1]`.
- `ena=0` while IDLE with `req=4'b1111` → `gnt` stays 0; `ena=0` during grant → grant completes, then no new grant.

Source files
------------

// File: rtl/uio_bus_arbiter_if.sv
// uio_bus_arbiter_if: requester-side and pin-side signals of the uio bus arbiter.
//
// Handshake: a requester raises req[i] (with dir[i]) and holds it until it
// sees gnt[i]. Every cycle gnt[i] is high is one beat: output owners have
// wdata driven on the pins and input owners have uio_in sampled. The grant
// ends after the beat in which the owner raises last[i] or drops req[i], or
// after the burst limit is reached. gnt is never combinationally dependent
// on req, last or dir.
interface uio_bus_arbiter_if #(
    parameter int NREQ = 4
);
    logic              ena;
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   dir;
    logic [NREQ-1:0]   last;
    logic [8*NREQ-1:0] wdata;
    logic [NREQ-1:0]   gnt;
    logic [7:0]        rdata;
    logic              rdata_valid;
    logic [7:0]        uio_in;
    logic [7:0]        uio_out;
    logic [7:0]        uio_oe;
    logic [1:0]        state_dbg;

    // User logic and pad side.
    modport master (
        output ena, req, dir, last, wdata, uio_in,
        input  gnt, rdata, rdata_valid, uio_out, uio_oe, state_dbg
    );

    // Arbiter side.
    modport slave (
        input  ena, req, dir, last, wdata, uio_in,
        output gnt, rdata, rdata_valid, uio_out, uio_oe, state_dbg
    );
endinterface

// File: rtl/uio_bus_arbiter.sv
// uio_bus_arbiter: round-robin sharing of the 8-bit bidirectional uio pins.
// One owner at a time; turnaround cycles with the pins released are inserted
// whenever the pin direction changes between owners.
module uio_bus_arbiter #(
    parameter int NREQ       = 4,
    parameter int MAX_BURST  = 8,
    parameter int TURNAROUND = 1
) (
    input logic              clk,
    input logic              rst,
    uio_bus_arbiter_if.slave bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int TW = $clog2(TURNAROUND + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TURN = 2'd1,
        OWN  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic          own_dir_q, own_dir_d;
    logic          bus_dir_q, bus_dir_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [TW-1:0] turn_q, turn_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          rvalid_q, rvalid_d;

    logic          sel_found;
    logic [IW-1:0] sel_idx;
    int            rr_idx;
    logic          grant_end;
    logic [IW-1:0] owner_next_ptr;

    logic [NREQ-1:0] gnt;
    logic [7:0]      uio_out;
    logic [7:0]      uio_oe;
    logic [7:0]      wbyte [NREQ];

    // Split the packed write-data bus into one byte per requester.
    for (genvar g = 0; g < NREQ; g++) begin : g_wbyte
        assign wbyte[g] = bus.wdata[8*g+7 : 8*g];
    end

    // Round-robin pick: first requesting index at or above ptr, wrapping.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        rr_idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            rr_idx = int'(ptr_q) + k;
            if (rr_idx >= NREQ) begin
                rr_idx = rr_idx - NREQ;
            end
            if (!sel_found && bus.req[IW'(rr_idx)]) begin
                sel_found = 1'b1;
                sel_idx   = IW'(rr_idx);
            end
        end
    end

    assign owner_next_ptr = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);
    assign grant_end      = bus.last[owner_q] || !bus.req[owner_q] ||
                            (beat_q == BW'(MAX_BURST - 1));

    // Next-state and next-register logic for the ownership FSM.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        own_dir_d = own_dir_q;
        bus_dir_d = bus_dir_q;
        beat_d    = beat_q;
        turn_d    = turn_q;
        rdata_d   = rdata_q;
        rvalid_d  = 1'b0;
        case (state_q)
            IDLE: begin
                beat_d = '0;
                turn_d = '0;
                if (bus.ena && sel_found) begin
                    owner_d   = sel_idx;
                    own_dir_d = bus.dir[sel_idx];
                    state_d   = (bus.dir[sel_idx] == bus_dir_q) ? OWN : TURN;
                end
            end
            TURN: begin
                if (turn_q == TW'(TURNAROUND - 1)) begin
                    turn_d    = '0;
                    bus_dir_d = own_dir_q;
                    state_d   = OWN;
                end else begin
                    turn_d = turn_q + TW'(1);
                end
            end
            OWN: begin
                // Input owners get every owned cycle's pin value captured.
                if (!own_dir_q) begin
                    rdata_d  = bus.uio_in;
                    rvalid_d = 1'b1;
                end
                beat_d = beat_q + BW'(1);
                if (grant_end) begin
                    beat_d  = '0;
                    ptr_d   = owner_next_ptr;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset releases the pins immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            ptr_q     <= '0;
            own_dir_q <= 1'b0;
            bus_dir_q <= 1'b0;
            beat_q    <= '0;
            turn_q    <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            own_dir_q <= own_dir_d;
            bus_dir_q <= bus_dir_d;
            beat_q    <= beat_d;
            turn_q    <= turn_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
        end
    end

    // Grant and pin drive decoded purely from registered state and owner.
    always_comb begin
        gnt     = '0;
        uio_oe  = 8'h00;
        uio_out = 8'h00;
        if (state_q == OWN) begin
            gnt[owner_q] = 1'b1;
            if (own_dir_q) begin
                uio_oe  = 8'hFF;
                uio_out = wbyte[owner_q];
            end
        end
    end

    assign bus.gnt         = gnt;
    assign bus.uio_oe      = uio_oe;
    assign bus.uio_out     = uio_out;
    assign bus.rdata       = rdata_q;
    assign bus.rdata_valid = rvalid_q;
    assign bus.state_dbg   = state_q;
endmodule

// File: tb/tb_uio_bus_arbiter.sv
// tb_uio_bus_arbiter: directed checks of the uio bus arbiter with
// hand-computed expectations (NREQ=4, MAX_BURST=8, TURNAROUND=1).
module tb_uio_bus_arbiter;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_TURN = 2'd1;
    localparam logic [1:0] S_OWN  = 2'd2;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    uio_bus_arbiter_if #(.NREQ(4)) bus ();

    uio_bus_arbiter #(
        .NREQ      (4),
        .MAX_BURST (8),
        .TURNAROUND(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Clock: 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int order [5];
        logic [3:0] exp_g;
        order = '{0, 1, 2, 3, 0};
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        bus.ena    = 1'b1;
        bus.req    = '0;
        bus.dir    = '0;
        bus.last   = '0;
        bus.wdata  = '0;
        bus.uio_in = '0;
        repeat (2) tick();
        rst = 1'b0;

        // Reset values
        check("rst_gnt", bus.gnt, 0);
        check("rst_oe", bus.uio_oe, 0);
        check("rst_out", bus.uio_out, 0);
        check("rst_rdata", bus.rdata, 0);
        check("rst_rvalid", bus.rdata_valid, 0);
        check("rst_state", bus.state_dbg, S_IDLE);

        // Input owner: requester 2, bus already in read direction, no turnaround
        bus.req = 4'b0100; bus.dir = 4'b0000; bus.uio_in = 8'h10;
        tick();
        check("in_gnt1", bus.gnt, 4'b0100);
        check("in_state1", bus.state_dbg, S_OWN);
        check("in_oe1", bus.uio_oe, 0);
        check("in_rvalid1", bus.rdata_valid, 0);
        tick();
        check("in_gnt2", bus.gnt, 4'b0100);
        check("in_rdata2", bus.rdata, 8'h10);
        check("in_rvalid2", bus.rdata_valid, 1);
        check("in_oe2", bus.uio_oe, 0);
        bus.uio_in = 8'h11;
        tick();
        check("in_gnt3", bus.gnt, 4'b0100);
        check("in_rdata3", bus.rdata, 8'h11);
        check("in_rvalid3", bus.rdata_valid, 1);
        bus.uio_in = 8'h12; bus.last = 4'b0100;
        tick();
        check("in_gnt_end", bus.gnt, 0);
        check("in_rdata4", bus.rdata, 8'h12);
        check("in_rvalid4", bus.rdata_valid, 1);
        bus.req = '0; bus.last = '0;
        tick();
        check("in_rvalid_off", bus.rdata_valid, 0);
        check("in_rdata_hold", bus.rdata, 8'h12);

        // Single output owner: requester 1, direction change costs one TURN cycle
        bus.req = 4'b0010; bus.dir = 4'b0010; bus.wdata[15:8] = 8'h3C;
        tick();
        check("out_turn_state", bus.state_dbg, S_TURN);
        check("out_turn_gnt", bus.gnt, 0);
        check("out_turn_oe", bus.uio_oe, 0);
        tick();
        for (int b = 0; b < 3; b++) begin
            check("out_gnt", bus.gnt, 4'b0010);
            check("out_oe", bus.uio_oe, 8'hFF);
            check("out_data", bus.uio_out, 8'h3C);
            if (b == 2) bus.last = 4'b0010;
            tick();
        end
        check("out_end_gnt", bus.gnt, 0);
        check("out_end_oe", bus.uio_oe, 0);
        check("out_end_data", bus.uio_out, 0);
        check("out_end_state", bus.state_dbg, S_IDLE);
        bus.req = '0; bus.last = '0; bus.dir = '0;
        tick();

        // Direction switch: requester 0 out (bus already out), then requester 1 in
        bus.req = 4'b0001; bus.dir = 4'b0001; bus.wdata[7:0] = 8'h5A; bus.last = 4'b0001;
        tick();
        check("sw_gnt0", bus.gnt, 4'b0001);
        check("sw_oe0", bus.uio_oe, 8'hFF);
        check("sw_out0", bus.uio_out, 8'h5A);
        bus.req = 4'b0010; bus.dir = 4'b0000; bus.last = '0;
        tick();
        check("sw_idle_state", bus.state_dbg, S_IDLE);
        check("sw_idle_oe", bus.uio_oe, 0);
        check("sw_idle_gnt", bus.gnt, 0);
        tick();
        check("sw_turn_state", bus.state_dbg, S_TURN);
        check("sw_turn_oe", bus.uio_oe, 0);
        check("sw_turn_gnt", bus.gnt, 0);
        tick();
        check("sw_gnt1", bus.gnt, 4'b0010);
        check("sw_oe1", bus.uio_oe, 0);
        bus.last = 4'b0010;
        tick();
        check("sw_end_gnt", bus.gnt, 0);
        bus.req = '0; bus.last = '0;

        // Reset pulse while idle restores pointer, direction and rdata
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_state", bus.state_dbg, S_IDLE);
        check("rst2_rdata", bus.rdata, 0);

        // Round-robin with full bursts: 0,1,2,3,0 each MAX_BURST cycles
        bus.req = 4'b1111; bus.dir = 4'b0000;
        tick();
        for (int g = 0; g < 5; g++) begin
            exp_g = 4'b0001 << order[g];
            for (int b = 0; b < 8; b++) begin
                check("rr_gnt", bus.gnt, exp_g);
                tick();
            end
            check("rr_gap_gnt", bus.gnt, 0);
            check("rr_gap_state", bus.state_dbg, S_IDLE);
            if (g != 4) tick();
        end
        bus.req = '0;
        tick();

        // ena low while idle blocks grants; ena falling mid-grant lets it finish
        bus.ena = 1'b0; bus.req = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ena_block_gnt", bus.gnt, 0);
        end
        bus.ena = 1'b1;
        tick();
        check("ena_gnt_b0", bus.gnt, 4'b0010);
        bus.ena = 1'b0;
        for (int b = 1; b < 8; b++) begin
            tick();
            check("ena_gnt_run", bus.gnt, 4'b0010);
        end
        tick();
        check("ena_done_gnt", bus.gnt, 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("ena_hold_gnt", bus.gnt, 0);
        end
        bus.req = '0; bus.ena = 1'b1;
        tick();

        // Asynchronous reset mid-grant with requester 0 driving 8'hA5
        bus.req = 4'b0001; bus.dir = 4'b0001; bus.wdata[7:0] = 8'hA5;
        tick();
        check("mr_turn_state", bus.state_dbg, S_TURN);
        tick();
        check("mr_gnt", bus.gnt, 4'b0001);
        check("mr_oe", bus.uio_oe, 8'hFF);
        check("mr_out", bus.uio_out, 8'hA5);
        #2 rst = 1'b1;
        #1;
        check("mr_rst_gnt", bus.gnt, 0);
        check("mr_rst_oe", bus.uio_oe, 0);
        check("mr_rst_out", bus.uio_out, 0);
        check("mr_rst_state", bus.state_dbg, S_IDLE);
        check("mr_rst_rdata", bus.rdata, 0);
        bus.req = '0; bus.dir = '0;
        tick();
        rst = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
